load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage between execute and the load-result formatter. It accepts one load or store request from the core, runs a single-beat transaction on the data-memory bus, and applies store byte-lane alignment. For loads it returns the raw 32-bit word together with the original address and funct3, so the downstream formatter can perform byte/half extraction and extension. It also detects misaligned or illegal accesses and bus response timeouts.

Parameters:
RESP_TIMEOUT, 256, cycles to wait in WAIT for mem_rvalid before flagging bus_error (min 2); counter width = $clog2(RESP_TIMEOUT+1)

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
lsu_valid  input  1  core request valid
lsu_ready  output  1  unit can accept a request (state IDLE)
lsu_is_store  input  1  1 = store, 0 = load
lsu_funct3  input  3  RV32I load/store funct3
lsu_address  input  32  byte address (addr_t)
lsu_store_data  input  32  rs2 value (data_t)
mem_req  output  1  bus request, held until mem_gnt
mem_we  output  1  bus write enable
mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  output  32  lane-aligned store data
mem_be  output  4  byte enables (0 for loads)
mem_gnt  input  1  bus accepts request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data
load_data  output  32  raw word for formatter (data_t)
load_address  output  32  captured byte address
load_funct3  output  3  captured funct3
done  output  1  one-cycle completion pulse
misaligned  output  1  qualifies done: access rejected, no bus traffic
bus_error  output  1  qualifies done: response timeout

Behaviour:
- Reset (async, immediate): state=IDLE; lsu_ready=1; mem_req, mem_we, done, misaligned, and bus_error = 0; mem_addr, mem_wdata, load_data, and load_address = 0; mem_be=0; load_funct3=0. Reset mid-transaction abandons it with no done pulse; any later mem_rvalid is ignored while in IDLE.
- All outputs are registered except lsu_ready, which equals (state==IDLE).
- States: IDLE, REQ, WAIT, DONE.
- IDLE: when lsu_valid is high, capture address, funct3, is_store and store data, then run the legality check:
  - Legal loads: 000/100 at any offset; 001/101 at offset 0,1,2; 010 at offset 0.
  - Legal stores: 000 at any offset; 001 at offset 0,1,2; 010 at offset 0.
  - Any other funct3 or offset is illegal.
  - Illegal -> DONE with misaligned=1; mem_req is never raised.
  - Legal -> REQ.
- Store lanes (off=addr[1:0]):
  - sb: mem_be=4'b0001<<off; mem_wdata={4{data[7:0]}}.
  - sh: mem_be=4'b0011<<off; mem_wdata=data[15:0]<<(8*off), other bits 0.
  - sw: mem_be=4'hF; mem_wdata=data.
- REQ: mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_gnt. Handling on the mem_gnt cycle:
  - Store: -> DONE.
  - Load with mem_rvalid also high: capture mem_rdata, -> DONE.
  - Load otherwise: -> WAIT with the timeout counter cleared.
  - mem_req drops the cycle after mem_gnt.
  - mem_rvalid before grant is ignored.
- WAIT: the counter increments each cycle.
  - mem_rvalid: load_data<=mem_rdata, -> DONE.
  - Counter reaches RESP_TIMEOUT-1 with no rvalid: load_data<=0, bus_error=1, -> DONE.
- DONE: done=1 for exactly one cycle; flags and load_* stay valid that cycle. Next cycle: done, misaligned and bus_error return to 0; state=IDLE. load_* hold until the next accept.
- Latency: accept in cycle 0; mem_req high in cycle 1. With gnt in cycle 1, done is high in cycle 2. A load with rvalid k cycles after gnt has done at cycle 2+k. A misaligned access has done in cycle 1.
- lsu_valid while not IDLE is ignored (not accepted).

Test Plan:
- Reset: reset high while in WAIT -> mem_req=0, done=0, and lsu_ready=1 immediately; a stale mem_rvalid=1 afterwards -> no done.
- Store byte: sb, addr=0x1003, data=0xAABBCCDD, gnt in cycle 1 -> mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xDDDDDDDD, mem_we=1; done at cycle 2.
- Store half: sh, addr=0x2002, data=0x00001234 -> mem_be=4'b1100, mem_wdata=0x12340000.
- Load with wait: lb, addr=0x1001, gnt cycle 1, rvalid cycle 4 with rdata=0x11228033 -> done at cycle 5; load_data=0x11228033, load_address=0x1001, load_funct3=000.
- Misaligned: lw at 0x1002, then lh at 0x1003, then funct3=011 load -> each gives done=1 and misaligned=1 at cycle 1, mem_req never asserted.
- Timeout: RESP_TIMEOUT=4, load granted with rvalid never asserted -> done=1, bus_error=1, load_data=0 exactly 4 cycles after entering WAIT; back-to-back request accepted the following cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// Single-beat load/store bus stage: legality check, store lane alignment,
// bus handshake and response timeout. Loads return the raw word for a downstream formatter.
module load_store_unit #(
  parameter int RESP_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_is_store,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_address,
  input  logic [31:0] lsu_store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic [31:0] load_address,
  output logic [2:0]  load_funct3,
  output logic        done,
  output logic        misaligned,
  output logic        bus_error
);

  localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] load_address_q, load_address_d;
  logic [2:0]  load_funct3_q, load_funct3_d;
  logic        done_q, done_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_error_q, bus_error_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]  off_s;
  logic        legal_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;

  assign off_s = lsu_address[1:0];

  // Access legality: the access must fit inside one word and use a defined funct3
  always_comb begin
    legal_s = 1'b0;
    case (lsu_funct3)
      3'b000:  legal_s = 1'b1;
      3'b100:  legal_s = !lsu_is_store;
      3'b001:  legal_s = (off_s != 2'b11);
      3'b101:  legal_s = !lsu_is_store && (off_s != 2'b11);
      3'b010:  legal_s = (off_s == 2'b00);
      default: legal_s = 1'b0;
    endcase
  end

  // Store byte-lane placement; loads never assert byte enables
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = lsu_store_data;
    case (lsu_funct3[1:0])
      2'b00: begin
        be_s    = 4'b0001 << off_s;
        wdata_s = {4{lsu_store_data[7:0]}};
      end
      2'b01: begin
        be_s    = 4'b0011 << off_s;
        wdata_s = {16'h0000, lsu_store_data[15:0]} << {off_s, 3'b000};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = lsu_store_data;
      end
    endcase
    if (!lsu_is_store) begin
      be_s = 4'b0000;
    end else begin
      be_s = be_s;
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    is_store_d     = is_store_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_be_d       = mem_be_q;
    load_data_d    = load_data_q;
    load_address_d = load_address_q;
    load_funct3_d  = load_funct3_q;
    done_d         = done_q;
    misaligned_d   = misaligned_q;
    bus_error_d    = bus_error_q;
    cnt_d          = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (lsu_valid) begin
          is_store_d     = lsu_is_store;
          load_address_d = lsu_address;
          load_funct3_d  = lsu_funct3;
          load_data_d    = 32'h0000_0000;
          if (legal_s) begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = lsu_is_store;
            mem_addr_d  = {lsu_address[31:2], 2'b00};
            mem_be_d    = be_s;
            mem_wdata_d = wdata_s;
          end else begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            misaligned_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (is_store_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (mem_rvalid) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            load_data_d = mem_rdata;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        // A response on the final counted cycle still wins over the timeout
        if (mem_rvalid) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          load_data_d = mem_rdata;
        end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          bus_error_d = 1'b1;
          load_data_d = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        bus_error_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      is_store_q     <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 32'h0000_0000;
      mem_wdata_q    <= 32'h0000_0000;
      mem_be_q       <= 4'b0000;
      load_data_q    <= 32'h0000_0000;
      load_address_q <= 32'h0000_0000;
      load_funct3_q  <= 3'b000;
      done_q         <= 1'b0;
      misaligned_q   <= 1'b0;
      bus_error_q    <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      is_store_q     <= is_store_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      load_data_q    <= load_data_d;
      load_address_q <= load_address_d;
      load_funct3_q  <= load_funct3_d;
      done_q         <= done_d;
      misaligned_q   <= misaligned_d;
      bus_error_q    <= bus_error_d;
      cnt_q          <= cnt_d;
    end
  end

  assign lsu_ready    = (state_q == S_IDLE);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_be       = mem_be_q;
  assign load_data    = load_data_q;
  assign load_address = load_address_q;
  assign load_funct3  = load_funct3_q;
  assign done         = done_q;
  assign misaligned   = misaligned_q;
  assign bus_error    = bus_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against a word-level access model.
module tb_load_store_unit;

  localparam int RESP_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_valid, lsu_ready, lsu_is_store;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_address, lsu_store_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [31:0] load_data, load_address;
  logic [2:0]  load_funct3;
  logic        done, misaligned, bus_error;

  int n_asserts = 0;
  int n_fail = 0;

  load_store_unit #(.RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_is_store(lsu_is_store),
    .lsu_funct3(lsu_funct3), .lsu_address(lsu_address), .lsu_store_data(lsu_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .load_data(load_data), .load_address(load_address), .load_funct3(load_funct3),
    .done(done), .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes must fit in the word from its offset.
  function automatic bit legal_m(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int off;
    int nbytes;
    off = int'(a % 4);
    if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    nbytes = 1 << f3[1:0];
    return (off + nbytes) <= 4;
  endfunction

  function automatic logic [3:0] be_m(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    int mask;
    if (!st) return 4'b0000;
    nbytes = 1 << f3[1:0];
    mask = ((1 << nbytes) - 1) << (a % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] wdata_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) << (8 * (a % 4));
      default: return d;
    endcase
  endfunction

  task automatic drive_junk();
    lsu_valid      = 1'($urandom_range(0, 1));
    lsu_is_store   = 1'($urandom_range(0, 1));
    lsu_funct3     = 3'($urandom_range(0, 7));
    lsu_address    = $urandom;
    lsu_store_data = $urandom;
  endtask

  // One complete access starting in an IDLE cycle; returns in the following IDLE cycle.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input int gnt_wait, input int rv_wait,
                         input bit rv_never, input logic [31:0] rdata);
    bit lg;
    bit waits;
    int nwait;
    lg = legal_m(st, f3, addr);
    waits = !st && (rv_never || rv_wait > 0);
    nwait = rv_never ? RESP_TIMEOUT : rv_wait;
    chk("idle_ready", lsu_ready, 1'b1);
    chk("idle_done", done, 1'b0);
    chk("idle_mis", misaligned, 1'b0);
    chk("idle_berr", bus_error, 1'b0);
    lsu_valid = 1'b1; lsu_is_store = st; lsu_funct3 = f3;
    lsu_address = addr; lsu_store_data = data;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    drive_junk();
    if (lg) begin
      for (int g = 0; g <= gnt_wait; g++) begin
        chk("req_mem_req", mem_req, 1'b1);
        chk("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("req_we", mem_we, st);
        chk("req_be", mem_be, be_m(st, f3, addr));
        if (st) chk("req_wdata", mem_wdata, wdata_m(f3, addr, data));
        chk("req_done", done, 1'b0);
        chk("req_ready", lsu_ready, 1'b0);
        mem_gnt = (g == gnt_wait);
        mem_rvalid = (g == gnt_wait) ? (!st && !waits) : 1'($urandom_range(0, 1));
        mem_rdata = (g == gnt_wait) ? rdata : $urandom;
        @(negedge clk);
        drive_junk();
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (waits) begin
        for (int w = 1; w <= nwait; w++) begin
          chk("wait_mem_req", mem_req, 1'b0);
          chk("wait_done", done, 1'b0);
          mem_rvalid = !rv_never && (w == rv_wait);
          mem_rdata = mem_rvalid ? rdata : $urandom;
          @(negedge clk);
          drive_junk();
        end
        mem_rvalid = 1'b0;
      end
    end
    chk("done_pulse", done, 1'b1);
    chk("done_mis", misaligned, !lg);
    chk("done_berr", bus_error, lg && !st && rv_never);
    chk("done_mem_req", mem_req, 1'b0);
    chk("done_ready", lsu_ready, 1'b0);
    chk("done_laddr", load_address, addr);
    chk("done_lf3", load_funct3, f3);
    if (lg && !st) chk("done_ldata", load_data, rv_never ? 32'h0 : rdata);
    @(negedge clk);
    lsu_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; lsu_valid = 1'b0; lsu_is_store = 1'b0; lsu_funct3 = 3'd0;
    lsu_address = 32'h0; lsu_store_data = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("rst_ready", lsu_ready, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", mem_be, 4'h0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_laddr", load_address, 32'h0);
    chk("rst_lf3", load_funct3, 3'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", {misaligned, bus_error}, 2'b00);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 1'b0, 32'h0);
    run_txn(1'b1, 3'd1, 32'h0000_2002, 32'h0000_1234, 0, 0, 1'b0, 32'h0);
    run_txn(1'b0, 3'd0, 32'h0000_1001, 32'h0, 0, 3, 1'b0, 32'h1122_8033);
    run_txn(1'b0, 3'd2, 32'h0000_1002, 32'h0, 0, 0, 1'b0, 32'h0);
    run_txn(1'b0, 3'd1, 32'h0000_1003, 32'h0, 0, 0, 1'b0, 32'h0);
    run_txn(1'b0, 3'd3, 32'h0000_1000, 32'h0, 0, 0, 1'b0, 32'h0);
    run_txn(1'b0, 3'd2, 32'h0000_3000, 32'h0, 0, 0, 1'b1, 32'h0);
    run_txn(1'b1, 3'd2, 32'h0000_3004, 32'h5566_7788, 0, 0, 1'b0, 32'h0);
    run_txn(1'b0, 3'd5, 32'h0000_3006, 32'h0, 2, RESP_TIMEOUT, 1'b0, 32'hCAFE_F00D);
    run_txn(1'b0, 3'd4, 32'h0000_3007, 32'h0, 1, 0, 1'b0, 32'h0BAD_BEEF);

    for (int i = 0; i < 80; i++) begin
      int k;
      k = $urandom_range(0, RESP_TIMEOUT + 1);
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom_range(0, 2), (k > RESP_TIMEOUT) ? 0 : k, k > RESP_TIMEOUT, $urandom);
    end

    // Reset while a load is waiting for its response
    lsu_valid = 1'b1; lsu_is_store = 1'b0; lsu_funct3 = 3'd2; lsu_address = 32'h40;
    @(negedge clk);
    lsu_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("pre_rst_ready", lsu_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req", mem_req, 1'b0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_ready", lsu_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stale_rvalid_done", done, 1'b0);
      chk("stale_rvalid_ready", lsu_ready, 1'b1);
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    run_txn(1'b0, 3'd0, 32'h0000_0050, 32'h0, 0, 1, 1'b0, 32'h8765_4321);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
